serial_io_buffer: RTL and testbench

- Byte-stream buffer between the processor's serial IO ports and an external host byte link (UART core or testbench driver).
- RX FIFO: host bytes are queued and presented to the processor as serial_in / serial_valid_in; each serial_rden_out pulse pops one byte.
- TX FIFO: the processor writes bytes via serial_out / serial_wren_out, gated by serial_ready_in; the host drains them over a valid/ready handshake.
- Provides sticky error flags and fill levels for debug.

---
 rtl/serial_io_pkg.sv | 8 +
 rtl/byte_fifo.sv | 39 +++
 rtl/serial_io_buffer.sv | 62 ++++++
 tb/tb_serial_io_buffer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_io_pkg.sv
// serial_io_pkg: shared byte width and width helper for the serial IO buffer.
package serial_io_pkg;
  localparam int BYTE_W = 8;
  function automatic int clog2(input int n);
    clog2 = 0;
    for (int v = n - 1; v > 0; v = v >> 1) clog2++;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular byte FIFO with wrap-bit pointers and zero-latency head read.
module byte_fifo import serial_io_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level
);
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];
  // Fullness and emptiness are judged on start-of-cycle pointers only.
  always_comb begin
    wr_d = wr_q + (AW+1)'(push && !full);
    rd_d = rd_q + (AW+1)'(pop && !empty);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/serial_io_buffer.sv
// serial_io_buffer: RX/TX byte FIFOs between a host byte link and processor serial ports,
// with sticky error flags and fill levels.
module serial_io_buffer import serial_io_pkg::*; #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        host_rx_data,
  input  logic                     host_rx_valid,
  output logic                     host_rx_ready,
  output logic [BYTE_W-1:0]        serial_in,
  output logic                     serial_valid_in,
  input  logic                     serial_rden_out,
  input  logic [BYTE_W-1:0]        serial_out,
  input  logic                     serial_wren_out,
  output logic                     serial_ready_in,
  output logic [BYTE_W-1:0]        host_tx_data,
  output logic                     host_tx_valid,
  input  logic                     host_tx_ready,
  output logic [clog2(RX_DEPTH):0] rx_level,
  output logic [clog2(TX_DEPTH):0] tx_level,
  output logic                     rx_overflow,
  output logic                     rx_underflow,
  output logic                     tx_overflow,
  input  logic                     clear_flags
);
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_ovf_q, rx_ovf_d, rx_udf_q, rx_udf_d, tx_ovf_q, tx_ovf_d;
  byte_fifo #(.DEPTH(RX_DEPTH)) rx_fifo (
    .clock(clock), .reset(reset), .push(host_rx_valid), .pop(serial_rden_out),
    .din(host_rx_data), .dout(serial_in), .empty(rx_empty), .full(rx_full), .level(rx_level)
  );
  byte_fifo #(.DEPTH(TX_DEPTH)) tx_fifo (
    .clock(clock), .reset(reset), .push(serial_wren_out), .pop(host_tx_ready),
    .din(serial_out), .dout(host_tx_data), .empty(tx_empty), .full(tx_full), .level(tx_level)
  );
  assign host_rx_ready   = !rx_full;
  assign serial_valid_in = !rx_empty;
  assign serial_ready_in = !tx_full;
  assign host_tx_valid   = !tx_empty;
  assign rx_overflow     = rx_ovf_q;
  assign rx_underflow    = rx_udf_q;
  assign tx_overflow     = tx_ovf_q;
  // A setting event in the same cycle as clear_flags leaves the flag set.
  always_comb begin
    rx_ovf_d = (host_rx_valid && rx_full) || (rx_ovf_q && !clear_flags);
    rx_udf_d = (serial_rden_out && rx_empty) || (rx_udf_q && !clear_flags);
    tx_ovf_d = (serial_wren_out && tx_full) || (tx_ovf_q && !clear_flags);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      rx_udf_q <= rx_udf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_io_buffer.sv
// tb_serial_io_buffer: directed and randomized checks of serial_io_buffer against a queue model.
module tb_serial_io_buffer;
  logic clock = 0, reset = 0;
  logic [7:0] host_rx_data = 0, serial_out = 0;
  logic host_rx_valid = 0, serial_rden_out = 0, serial_wren_out = 0, host_tx_ready = 0, clear_flags = 0;
  logic [7:0] serial_in, host_tx_data;
  logic host_rx_ready, serial_valid_in, serial_ready_in, host_tx_valid;
  logic [4:0] rx_level, tx_level;
  logic rx_overflow, rx_underflow, tx_overflow;
  int checks = 0, failures = 0;
  logic [7:0] rxq[$], txq[$];
  bit m_rxo, m_rxu, m_txo;

  serial_io_buffer dut (
    .clock(clock), .reset(reset), .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready), .serial_in(serial_in), .serial_valid_in(serial_valid_in),
    .serial_rden_out(serial_rden_out), .serial_out(serial_out), .serial_wren_out(serial_wren_out),
    .serial_ready_in(serial_ready_in), .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready), .rx_level(rx_level), .tx_level(tx_level),
    .rx_overflow(rx_overflow), .rx_underflow(rx_underflow), .tx_overflow(tx_overflow),
    .clear_flags(clear_flags)
  );

  always #5 clock = ~clock;

  task automatic model_clear();
    rxq.delete();
    txq.delete();
    m_rxo = 0;
    m_rxu = 0;
    m_txo = 0;
  endtask

  // Advance one clock; the model consumes the inputs as seen before the edge.
  task automatic cycle();
    bit rxf = rxq.size() == 16, txf = txq.size() == 16;
    bit rx_push = host_rx_valid && !rxf, rx_pop = serial_rden_out && rxq.size() != 0;
    bit tx_push = serial_wren_out && !txf, tx_pop = host_tx_ready && txq.size() != 0;
    bit ro = host_rx_valid && rxf, ru = serial_rden_out && rxq.size() == 0, to = serial_wren_out && txf;
    bit cf = clear_flags;
    logic [7:0] rd = host_rx_data, td = serial_out;
    @(posedge clock);
    #1;
    if (rx_pop) void'(rxq.pop_front());
    if (rx_push) rxq.push_back(rd);
    if (tx_pop) void'(txq.pop_front());
    if (tx_push) txq.push_back(td);
    m_rxo = ro || (m_rxo && !cf);
    m_rxu = ru || (m_rxu && !cf);
    m_txo = to || (m_txo && !cf);
  endtask

  task automatic test_reset();
    reset = 0;
    host_rx_valid = 1;
    host_rx_data = 8'h55;
    repeat (3) @(posedge clock);
    #1;
    host_rx_valid = 0;
    reset = 1;
    model_clear();
    #1;
    checks++;
    if ({host_rx_ready, serial_valid_in, serial_ready_in, host_tx_valid} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_handshake got=%b exp=1010", {host_rx_ready, serial_valid_in, serial_ready_in, host_tx_valid});
    end
    checks++;
    if ({rx_level, tx_level, rx_overflow, rx_underflow, tx_overflow} !== 13'd0) begin
      failures++;
      $display("FAIL reset_levels_flags got=%h exp=0", {rx_level, tx_level, rx_overflow, rx_underflow, tx_overflow});
    end
  endtask

  task automatic test_rx_order();
    logic [7:0] exp_b;
    host_rx_valid = 1;
    host_rx_data = 8'h41;
    cycle();
    checks++;
    if (serial_valid_in !== 1'b1 || serial_in !== 8'h41) begin
      failures++;
      $display("FAIL rx_first_visible got valid=%b data=%h exp valid=1 data=41", serial_valid_in, serial_in);
    end
    host_rx_data = 8'h42;
    cycle();
    host_rx_data = 8'h43;
    cycle();
    host_rx_valid = 0;
    checks++;
    if (rx_level !== 5'd3) begin
      failures++;
      $display("FAIL rx_level3 got=%0d exp=3", rx_level);
    end
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'h41 + 8'(i);
      checks++;
      if (serial_in !== exp_b) begin
        failures++;
        $display("FAIL rx_order got=%h exp=%h", serial_in, exp_b);
      end
      serial_rden_out = 1;
      cycle();
      serial_rden_out = 0;
    end
    checks++;
    if (serial_valid_in !== 1'b0) begin
      failures++;
      $display("FAIL rx_drained_valid got=%b exp=0", serial_valid_in);
    end
  endtask

  task automatic test_rx_full();
    host_rx_valid = 1;
    for (int i = 0; i < 16; i++) begin
      host_rx_data = 8'(i);
      cycle();
    end
    checks++;
    if ({host_rx_ready, rx_level, rx_overflow} !== {1'b0, 5'd16, 1'b0}) begin
      failures++;
      $display("FAIL rx_full got ready=%b level=%0d ovf=%b exp ready=0 level=16 ovf=0", host_rx_ready, rx_level, rx_overflow);
    end
    host_rx_data = 8'h10;
    cycle();
    host_rx_valid = 0;
    checks++;
    if (rx_overflow !== 1'b1 || rx_level !== 5'd16) begin
      failures++;
      $display("FAIL rx_overflow got ovf=%b level=%0d exp ovf=1 level=16", rx_overflow, rx_level);
    end
    serial_rden_out = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (serial_in !== 8'(i)) begin
        failures++;
        $display("FAIL rx_full_order got=%h exp=%h", serial_in, 8'(i));
      end
      cycle();
    end
    checks++;
    if (rx_underflow !== 1'b0) begin
      failures++;
      $display("FAIL rx_underflow_early got=%b exp=0", rx_underflow);
    end
    cycle();
    serial_rden_out = 0;
    checks++;
    if (rx_underflow !== 1'b1 || rx_level !== 5'd0) begin
      failures++;
      $display("FAIL rx_underflow got udf=%b level=%0d exp udf=1 level=0", rx_underflow, rx_level);
    end
  endtask

  task automatic test_tx_drop();
    host_tx_ready = 0;
    serial_wren_out = 1;
    for (int i = 0; i < 17; i++) begin
      serial_out = 8'h80 + 8'(i);
      cycle();
    end
    serial_wren_out = 0;
    checks++;
    if ({tx_level, tx_overflow, serial_ready_in} !== {5'd16, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL tx_drop got level=%0d ovf=%b ready=%b exp level=16 ovf=1 ready=0", tx_level, tx_overflow, serial_ready_in);
    end
    host_tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (host_tx_valid !== 1'b1 || host_tx_data !== 8'h80 + 8'(i)) begin
        failures++;
        $display("FAIL tx_drain got valid=%b data=%h exp valid=1 data=%h", host_tx_valid, host_tx_data, 8'h80 + 8'(i));
      end
      cycle();
    end
    host_tx_ready = 0;
    checks++;
    if (host_tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL tx_drain_empty got=%b exp=0", host_tx_valid);
    end
  endtask

  task automatic test_wrap();
    serial_wren_out = 1;
    serial_out = 8'hA0;
    cycle();
    host_tx_ready = 1;
    for (int i = 1; i < 40; i++) begin
      serial_out = 8'hA0 + 8'(i);
      checks++;
      if (host_tx_data !== 8'hA0 + 8'(i - 1) || tx_level !== 5'd1) begin
        failures++;
        $display("FAIL wrap_stream got data=%h level=%0d exp data=%h level=1", host_tx_data, tx_level, 8'hA0 + 8'(i - 1));
      end
      cycle();
    end
    serial_wren_out = 0;
    cycle();
    host_tx_ready = 0;
    checks++;
    if (tx_level !== 5'd0) begin
      failures++;
      $display("FAIL wrap_final_level got=%0d exp=0", tx_level);
    end
  endtask

  task automatic test_flags();
    clear_flags = 1;
    serial_rden_out = 1;
    cycle();
    serial_rden_out = 0;
    checks++;
    if ({rx_overflow, rx_underflow, tx_overflow} !== 3'b010) begin
      failures++;
      $display("FAIL flags_set_wins got=%b exp=010", {rx_overflow, rx_underflow, tx_overflow});
    end
    cycle();
    clear_flags = 0;
    checks++;
    if ({rx_overflow, rx_underflow, tx_overflow} !== 3'b000) begin
      failures++;
      $display("FAIL flags_clear got=%b exp=000", {rx_overflow, rx_underflow, tx_overflow});
    end
  endtask

  task automatic test_random();
    logic [16:0] got, exp_v;
    for (int n = 0; n < 600; n++) begin
      got = {rx_level, tx_level, host_rx_ready, serial_valid_in, serial_ready_in, host_tx_valid,
             rx_overflow, rx_underflow, tx_overflow};
      exp_v = {5'(rxq.size()), 5'(txq.size()), rxq.size() != 16, rxq.size() != 0, txq.size() != 16,
               txq.size() != 0, m_rxo, m_rxu, m_txo};
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL rnd_status cyc=%0d got=%h exp=%h", n, got, exp_v);
      end
      if (rxq.size() != 0) begin
        checks++;
        if (serial_in !== rxq[0]) begin
          failures++;
          $display("FAIL rnd_rx_head cyc=%0d got=%h exp=%h", n, serial_in, rxq[0]);
        end
      end
      if (txq.size() != 0) begin
        checks++;
        if (host_tx_data !== txq[0]) begin
          failures++;
          $display("FAIL rnd_tx_head cyc=%0d got=%h exp=%h", n, host_tx_data, txq[0]);
        end
      end
      host_rx_valid   = $urandom_range(0, 99) < ((n / 150) % 2 ? 30 : 70);
      serial_rden_out = $urandom_range(0, 99) < ((n / 150) % 2 ? 70 : 30);
      serial_wren_out = $urandom_range(0, 99) < ((n / 100) % 2 ? 75 : 35);
      host_tx_ready   = $urandom_range(0, 99) < ((n / 100) % 2 ? 25 : 70);
      clear_flags     = $urandom_range(0, 99) < 5;
      host_rx_data    = 8'($urandom);
      serial_out      = 8'($urandom);
      cycle();
    end
    {host_rx_valid, serial_rden_out, serial_wren_out, host_tx_ready, clear_flags} = '0;
  endtask

  task automatic test_mid_reset();
    host_rx_valid = 1;
    serial_wren_out = 1;
    for (int i = 0; i < 3; i++) begin
      host_rx_data = 8'h30 + 8'(i);
      serial_out = 8'h60 + 8'(i);
      cycle();
    end
    host_rx_valid = 0;
    serial_wren_out = 0;
    serial_rden_out = 1;
    cycle();
    serial_rden_out = 0;
    reset = 0;
    model_clear();
    #1;
    checks++;
    if ({rx_level, tx_level, serial_valid_in, host_tx_valid, rx_underflow} !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0", {rx_level, tx_level, serial_valid_in, host_tx_valid, rx_underflow});
    end
    @(posedge clock);
    #1;
    reset = 1;
    cycle();
    checks++;
    if ({host_rx_ready, serial_valid_in, serial_ready_in, host_tx_valid, rx_level, tx_level} !== {4'b1010, 10'd0}) begin
      failures++;
      $display("FAIL after_mid_reset got=%h exp=%h", {host_rx_ready, serial_valid_in, serial_ready_in, host_tx_valid, rx_level, tx_level}, {4'b1010, 10'd0});
    end
  endtask

  initial begin
    test_reset();
    test_rx_order();
    test_rx_full();
    test_tx_drop();
    test_wrap();
    test_flags();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
